// File: rtl/serial_frame_rx.sv
// Multi-channel serial frame receiver: synchronises marker/bit-clock/data lines,
// deserialises each channel into words and tracks frame bookkeeping and errors.
module serial_frame_rx #(
  parameter int CHANNELS    = 2,
  parameter int WORD_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1,
  parameter int SAMPLE_EDGE = 0,
  parameter int WORDS_MAX   = 16,
  localparam int IDX_W      = ($clog2(WORDS_MAX) > 1) ? $clog2(WORDS_MAX) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       imk,
  input  logic                       iclk,
  input  logic [CHANNELS-1:0]        idat,
  output logic [CHANNELS*WORD_W-1:0] odat,
  output logic                       oval,
  output logic [IDX_W-1:0]           oidx,
  output logic                       osw,
  output logic                       oflush,
  output logic                       oerr_ovf,
  output logic                       oerr_short
);

  localparam int BC_W = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, FLUSH, RECV} state_t;

  logic [SYNC_STAGES-1:0]     mk_sync, ck_sync;
  logic [CHANNELS-1:0]        dat_sync [SYNC_STAGES];
  logic                       mk_hist, ck_hist;
  logic                       mk_front, smp_edge;
  logic [CHANNELS-1:0]        dat_bit;
  logic [CHANNELS*WORD_W-1:0] shreg, sh_next;
  logic [BC_W-1:0]            bitcnt;
  logic [IDX_W-1:0]           widx;
  logic                       full;
  state_t                     state;

  // Stage: synchronisers, all chains equally deep so data lines up with the clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mk_sync <= '0;
      ck_sync <= '0;
      mk_hist <= 1'b0;
      ck_hist <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) dat_sync[s] <= '0;
    end else begin
      mk_sync     <= {mk_sync[SYNC_STAGES-2:0], imk};
      ck_sync     <= {ck_sync[SYNC_STAGES-2:0], iclk};
      mk_hist     <= mk_sync[SYNC_STAGES-1];
      ck_hist     <= ck_sync[SYNC_STAGES-1];
      dat_sync[0] <= idat;
      for (int s = 1; s < SYNC_STAGES; s++) dat_sync[s] <= dat_sync[s-1];
    end
  end

  // Stage: edge detection and next shift-register value
  always_comb begin
    mk_front = mk_sync[SYNC_STAGES-1] & ~mk_hist;
    smp_edge = (SAMPLE_EDGE != 0) ? (ck_sync[SYNC_STAGES-1] & ~ck_hist)
                                  : (~ck_sync[SYNC_STAGES-1] & ck_hist);
    dat_bit  = dat_sync[SYNC_STAGES-1];
    sh_next  = shreg;
    for (int c = 0; c < CHANNELS; c++) begin
      if (MSB_FIRST != 0)
        sh_next[c*WORD_W +: WORD_W] = {shreg[c*WORD_W +: WORD_W-1], dat_bit[c]};
      else
        sh_next[c*WORD_W +: WORD_W] = {dat_bit[c], shreg[c*WORD_W+1 +: WORD_W-1]};
    end
  end

  // Stage: frame FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      widx       <= '0;
      full       <= 1'b0;
      shreg      <= '0;
      odat       <= '0;
      oval       <= 1'b0;
      oidx       <= '0;
      osw        <= 1'b0;
      oflush     <= 1'b0;
      oerr_ovf   <= 1'b0;
      oerr_short <= 1'b0;
    end else begin
      oval       <= 1'b0;
      oflush     <= 1'b0;
      oerr_short <= 1'b0;
      case (state)
        IDLE: begin
          if (mk_front) state <= FLUSH;
        end
        FLUSH: begin
          oflush     <= 1'b1;
          osw        <= ~osw;
          oerr_short <= (bitcnt != '0);
          oerr_ovf   <= 1'b0;
          bitcnt     <= '0;
          widx       <= '0;
          full       <= 1'b0;
          state      <= RECV;
        end
        RECV: begin
          // A marker front in the same cycle as a sample edge discards the bit
          if (mk_front) begin
            state <= FLUSH;
          end else if (smp_edge) begin
            if (full) begin
              oerr_ovf <= 1'b1;
            end else begin
              shreg <= sh_next;
              if (bitcnt == BC_W'(WORD_W-1)) begin
                odat   <= sh_next;
                oval   <= 1'b1;
                oidx   <= widx;
                widx   <= widx + 1'b1;
                bitcnt <= '0;
                if (widx == IDX_W'(WORDS_MAX-1)) full <= 1'b1;
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: default MSB-first/falling-edge instance plus
// LSB-first instances sampling on falling and rising edges, all on shared stimulus.
module tb_serial_frame_rx;

  localparam int HOLD = 6;

  logic       clk = 1'b0;
  logic       rst_n, imk, iclk;
  logic [1:0] idat;

  logic [15:0] odat, l_odat, r_odat;
  logic        oval, l_oval, r_oval;
  logic [3:0]  oidx, l_oidx, r_oidx;
  logic        osw, l_osw, r_osw;
  logic        oflush, l_oflush, r_oflush;
  logic        oerr_ovf, l_ovf, r_ovf;
  logic        oerr_short, l_short, r_short;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_frame_rx dut (
    .clk(clk), .reset(rst_n), .imk(imk), .iclk(iclk), .idat(idat),
    .odat(odat), .oval(oval), .oidx(oidx), .osw(osw), .oflush(oflush),
    .oerr_ovf(oerr_ovf), .oerr_short(oerr_short));

  serial_frame_rx #(.MSB_FIRST(0), .SAMPLE_EDGE(0)) dut_lsb (
    .clk(clk), .reset(rst_n), .imk(imk), .iclk(iclk), .idat(idat),
    .odat(l_odat), .oval(l_oval), .oidx(l_oidx), .osw(l_osw), .oflush(l_oflush),
    .oerr_ovf(l_ovf), .oerr_short(l_short));

  serial_frame_rx #(.MSB_FIRST(0), .SAMPLE_EDGE(1)) dut_rise (
    .clk(clk), .reset(rst_n), .imk(imk), .iclk(iclk), .idat(idat),
    .odat(r_odat), .oval(r_oval), .oidx(r_oidx), .osw(r_osw), .oflush(r_oflush),
    .oerr_ovf(r_ovf), .oerr_short(r_short));

  // Event recorder, sampled on the falling clock edge
  logic [15:0] vdat_q[$];
  logic [3:0]  vidx_q[$];
  int          flush_cnt = 0, short_flush_cnt = 0, short_alone_cnt = 0, consec_cnt = 0;
  int          l_cnt = 0, r_cnt = 0;
  logic [15:0] l_last = '0, r_last = '0;
  logic        prev_oval = 1'b0;

  always @(negedge clk) begin
    if (oval) begin
      vdat_q.push_back(odat);
      vidx_q.push_back(oidx);
    end
    if (oval && prev_oval) consec_cnt++;
    prev_oval = oval;
    if (oflush) flush_cnt++;
    if (oerr_short && oflush) short_flush_cnt++;
    if (oerr_short && !oflush) short_alone_cnt++;
    if (l_oval) begin l_cnt++; l_last = l_odat; end
    if (r_oval) begin r_cnt++; r_last = r_odat; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b0, input logic b1);
    idat = {b1, b0};
    cyc(HOLD);
    iclk = 1'b1;
    cyc(HOLD);
    iclk = 1'b0;
    cyc(HOLD);
  endtask

  task automatic send_word(input logic [7:0] c0, input logic [7:0] c1);
    for (int i = 7; i >= 0; i--) send_bit(c0[i], c1[i]);
  endtask

  task automatic marker();
    imk = 1'b1;
    cyc(HOLD);
    imk = 1'b0;
    cyc(HOLD);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_odat"}, 32'(odat), 32'h0);
    check({tag, "_oval"}, 32'(oval), 32'h0);
    check({tag, "_oidx"}, 32'(oidx), 32'h0);
    check({tag, "_osw"}, 32'(osw), 32'h0);
    check({tag, "_oflush"}, 32'(oflush), 32'h0);
    check({tag, "_ovf"}, 32'(oerr_ovf), 32'h0);
    check({tag, "_short"}, 32'(oerr_short), 32'h0);
  endtask

  initial begin
    int fc;
    logic [7:0] c0, c1;
    rst_n = 1'b0;
    imk   = 1'b0;
    iclk  = 1'b0;
    idat  = 2'b00;
    cyc(3);
    check_reset_outputs("rst");
    check("rst_lsb_odat", 32'(l_odat), 32'h0);
    rst_n = 1'b1;
    cyc(2);

    // Bit clocks without a marker are ignored
    send_word(8'hFF, 8'h55);
    check("nomk_oval_cnt", 32'(vdat_q.size()), 32'd0);
    check("nomk_osw", 32'(osw), 32'h0);
    check("nomk_flush", 32'(flush_cnt), 32'd0);

    // Two-word frame, MSB first
    marker();
    check("f1_flush_cnt", 32'(flush_cnt), 32'd1);
    check("f1_osw", 32'(osw), 32'h1);
    send_word(8'hA5, 8'h5A);
    send_word(8'h3C, 8'hC3);
    check("f1_nwords", 32'(vdat_q.size()), 32'd2);
    check("f1_w0_dat", 32'(vdat_q[0]), 32'h5AA5);
    check("f1_w0_idx", 32'(vidx_q[0]), 32'd0);
    check("f1_w1_dat", 32'(vdat_q[1]), 32'hC33C);
    check("f1_w1_idx", 32'(vidx_q[1]), 32'd1);

    // Bit order and sampling edge variants
    vdat_q.delete(); vidx_q.delete();
    l_cnt = 0; r_cnt = 0;
    marker();
    send_word(8'h80, 8'h00);
    check("lsb_cnt", 32'(l_cnt), 32'd1);
    check("lsb_dat", 32'(l_last), 32'h0001);
    check("rise_cnt", 32'(r_cnt), 32'd1);
    check("rise_dat", 32'(r_last), 32'h0001);
    check("msb_nwords", 32'(vdat_q.size()), 32'd1);
    check("msb_dat", 32'(vdat_q[0]), 32'h0080);
    check("msb_idx", 32'(vidx_q[0]), 32'd0);
    check("f2_osw", 32'(osw), 32'h0);

    // Overflow: 17 words into a 16-word frame
    vdat_q.delete(); vidx_q.delete();
    marker();
    check("ovf_osw", 32'(osw), 32'h1);
    for (int i = 0; i < 16; i++) send_word(8'(i + 1), 8'(8'hF0 ^ i));
    check("ovf_before", 32'(oerr_ovf), 32'h0);
    send_word(8'hEE, 8'hDD);
    check("ovf_after", 32'(oerr_ovf), 32'h1);
    check("ovf_nwords", 32'(vdat_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      c0 = 8'(i + 1);
      c1 = 8'(8'hF0 ^ i);
      check($sformatf("ovf_dat%0d", i), 32'(vdat_q[i]), 32'({c1, c0}));
      check($sformatf("ovf_idx%0d", i), 32'(vidx_q[i]), 32'(i));
    end
    marker();
    check("ovf_clear", 32'(oerr_ovf), 32'h0);
    check("ovf_osw_next", 32'(osw), 32'h0);
    check("ovf_no_short", 32'(short_flush_cnt), 32'd0);

    // Short frame: 5 bits then a new marker
    vdat_q.delete(); vidx_q.delete();
    marker();
    check("sh_osw", 32'(osw), 32'h1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check("sh_short_before", 32'(short_flush_cnt), 32'd0);
    marker();
    check("sh_short_with_flush", 32'(short_flush_cnt), 32'd1);
    check("sh_short_alone", 32'(short_alone_cnt), 32'd0);
    check("sh_no_oval", 32'(vdat_q.size()), 32'd0);
    check("sh_osw2", 32'(osw), 32'h0);
    send_word(8'h12, 8'h34);
    check("sh_nwords", 32'(vdat_q.size()), 32'd1);
    check("sh_idx", 32'(vidx_q[0]), 32'd0);
    check("sh_dat", 32'(vdat_q[0]), 32'h3412);

    // Reset mid-frame after three words
    marker();
    check("mr_osw", 32'(osw), 32'h1);
    send_word(8'h11, 8'h22);
    send_word(8'h33, 8'h44);
    send_word(8'h55, 8'h66);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    rst_n = 1'b0;
    cyc(2);
    check_reset_outputs("mr");
    rst_n = 1'b1;
    cyc(2);
    vdat_q.delete(); vidx_q.delete();
    fc = flush_cnt;
    send_word(8'hAA, 8'h55);
    check("mr_ignored", 32'(vdat_q.size()), 32'd0);
    check("mr_osw_idle", 32'(osw), 32'h0);
    check("mr_no_flush", 32'(flush_cnt), 32'(fc));
    marker();
    check("mr_osw_new", 32'(osw), 32'h1);
    send_word(8'h01, 8'h02);
    check("mr_nwords", 32'(vdat_q.size()), 32'd1);
    check("mr_idx", 32'(vidx_q[0]), 32'd0);
    check("mr_dat", 32'(vdat_q[0]), 32'h0201);

    check("oval_consecutive", 32'(consec_cnt), 32'd0);
    check("short_without_flush", 32'(short_alone_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
